// File: rtl/vga_frame_scanner_pkg.sv
// Shared VGA timing types and helpers for the frame scanner.
// Holds the timing struct, the 640x480 preset and derived-size functions.
package vga_frame_scanner_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{640, 16, 96, 48};
  localparam vga_timing_t VGA_640X480_V = '{480, 10, 2, 33};

  function automatic int h_tot(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int v_tot(vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Offset that centres an image of size img inside full.
  function automatic int win_off(int full, int img);
    return (full - img) / 2;
  endfunction

endpackage

// File: rtl/vga_frame_scanner_if.sv
// Framebuffer read bus: address + one-clk read strobe out, pixel data back.
// master = scanner side, slave = memory side.
interface vga_frame_scanner_if #(
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [PIX_W-1:0]  mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data
  );
endinterface

// File: rtl/vga_frame_scanner_timing.sv
// Pixel divider, h/v scan counters and per-position decode.
// Ports: clk, reset in; pt, vga_clk, active, hs_n, vs_n, win, frame0 out.
module vga_timing_gen
  import vga_frame_scanner_pkg::*;
#(
  parameter vga_timing_t HT = VGA_640X480_H,
  parameter vga_timing_t VT = VGA_640X480_V,
  parameter int CLK_DIV = 2,
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256
) (
  input  logic clk,
  input  logic reset,
  output logic pt,
  output logic vga_clk,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic win,
  output logic frame0
);
  localparam int HTOT = h_tot(HT);
  localparam int VTOT = v_tot(VT);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int HS0  = HT.active + HT.fp;
  localparam int HS1  = HS0 + HT.sync;
  localparam int VS0  = VT.active + VT.fp;
  localparam int VS1  = VS0 + VT.sync;
  localparam int X0   = win_off(HT.active, IMG_W);
  localparam int Y0   = win_off(VT.active, IMG_H);

  logic [DW-1:0] div, div_nx;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_last, v_last;

  assign pt     = div == DW'(CLK_DIV - 1);
  assign div_nx = pt ? '0 : div + DW'(1);
  assign h_last = hc == HW'(HTOT - 1);
  assign v_last = vc == VW'(VTOT - 1);

  // vga_clk is registered from the next divider value so it never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      div     <= '0;
      hc      <= '0;
      vc      <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_nx;
      vga_clk <= div_nx >= DW'(CLK_DIV / 2);
      if (pt) begin
        hc <= h_last ? '0 : hc + HW'(1);
        if (h_last)
          vc <= v_last ? '0 : vc + VW'(1);
      end
    end
  end

  assign active = hc < HW'(HT.active) && vc < VW'(VT.active);
  assign hs_n   = !(hc >= HW'(HS0) && hc < HW'(HS1));
  assign vs_n   = !(vc >= VW'(VS0) && vc < VW'(VS1));
  assign win    = hc >= HW'(X0) && hc < HW'(X0 + IMG_W) &&
                  vc >= VW'(Y0) && vc < VW'(Y0 + IMG_H);
  assign frame0 = pt && hc == '0 && vc == '0;

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan-out: fetches the selected image centred on screen, border elsewhere.
// Ports: clk, reset, img_sel, mem (master), hsync/vsync/blank/sync, r/g/b, vga_clk, frame_start.
module vga_frame_scanner
  import vga_frame_scanner_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int MEM_LAT  = 1,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int NUM_IMG  = 2,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 17,
  parameter logic [7:0] BORDER = 8'h00,
  localparam int SEL_W = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] img_sel,
  vga_frame_scanner_if.master mem,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             sync,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             vga_clk,
  output logic             frame_start
);
  localparam vga_timing_t HT = '{H_ACTIVE, H_FP, H_SYNC, H_BP};
  localparam vga_timing_t VT = '{V_ACTIVE, V_FP, V_SYNC, V_BP};
  localparam int IMG_SZ = IMG_W * IMG_H;

  logic pt, active, hs_n, vs_n, win, frame0;

  vga_timing_gen #(
    .HT(HT), .VT(VT), .CLK_DIV(CLK_DIV),
    .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) u_timing (
    .clk(clk), .reset(reset), .pt(pt), .vga_clk(vga_clk),
    .active(active), .hs_n(hs_n), .vs_n(vs_n),
    .win(win), .frame0(frame0)
  );

  logic [SEL_W-1:0]  sel_q, sel_nx, sel_use;
  logic [ADDR_W-1:0] off_q, off_use, base;
  logic              hs_p, vs_p, act_p, win_p;
  logic [PIX_W-1:0]  pix_q, pix;
  logic [7:0]        pix8, rgb_nx;
  logic              rd_lat;

  // Frame start uses the freshly sampled select so the first read of a
  // full-screen image already points at the new base.
  assign sel_nx  = (int'(img_sel) >= NUM_IMG) ? '0 : img_sel;
  assign sel_use = frame0 ? sel_nx : sel_q;
  assign off_use = frame0 ? '0 : off_q;
  assign base    = ADDR_W'(sel_use) * ADDR_W'(IMG_SZ);

  // rd_lat marks the clk in which the framebuffer drives valid data.
  if (MEM_LAT == 0) begin : g_lat0
    assign rd_lat = mem.mem_rd;
  end else begin : g_latn
    logic [MEM_LAT-1:0] sh;
    always_ff @(posedge clk) begin
      if (reset) sh <= '0;
      else       sh <= MEM_LAT'({sh, mem.mem_rd});
    end
    assign rd_lat = sh[MEM_LAT-1];
  end

  // Bypass covers MEM_LAT = CLK_DIV-1, where data arrives on the pt edge.
  assign pix    = rd_lat ? mem.mem_data : pix_q;
  assign pix8   = 8'(pix) << (8 - PIX_W);
  assign rgb_nx = win_p ? pix8 : (act_p ? BORDER : 8'h00);
  assign sync   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= '0;
      off_q        <= '0;
      pix_q        <= '0;
      mem.mem_addr <= '0;
      mem.mem_rd   <= 1'b0;
      frame_start  <= 1'b0;
      hs_p         <= 1'b1;
      vs_p         <= 1'b1;
      act_p        <= 1'b0;
      win_p        <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      blank        <= 1'b0;
      r            <= '0;
      g            <= '0;
      b            <= '0;
    end else begin
      mem.mem_rd  <= 1'b0;
      frame_start <= 1'b0;
      if (rd_lat) pix_q <= mem.mem_data;
      if (pt) begin
        frame_start <= frame0;
        if (frame0) begin
          sel_q <= sel_nx;
          off_q <= '0;
        end
        if (win) begin
          mem.mem_addr <= base + off_use;
          mem.mem_rd   <= 1'b1;
          off_q        <= off_use + ADDR_W'(1);
        end
        hs_p  <= hs_n;
        vs_p  <= vs_n;
        act_p <= active;
        win_p <= win;
        hsync <= hs_p;
        vsync <= vs_p;
        blank <= act_p;
        r     <= rgb_nx;
        g     <= rgb_nx;
        b     <= rgb_nx;
      end
    end
  end

endmodule
